// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } ram_cmd_t;

    typedef enum logic {PRI_A, PRI_B} pri_state_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Per-requester command/response bundle; the requester drives master, the arbiter is slave.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
    modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    pri_state_t state_q, state_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (state_q == PRI_A) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // The pointer always swings to the port that did not just win.
    always_comb begin
        state_d = state_q;
        if (adv) begin
            if (gnt[PORT_A]) begin
                state_d = PRI_B;
            end else if (gnt[PORT_B]) begin
                state_d = PRI_A;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRI_A;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/simple_sync_ram.sv
// Single-port synchronous RAM: one-cycle registered read, read-before-write.
module simple_sync_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        dout <= mem[addr];
        if (we) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port sync RAM between requesters A and B; responses are
// routed back through a two-stage owner/valid pipeline matching the RAM latency.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_port_arbiter_if.slave     a_if,
    ram_port_arbiter_if.slave     b_if,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic [1:0] gnt;
    logic       adv;

    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    logic                  v1_q, v1_d;
    logic                  own1_q, own1_d;
    logic                  v2_q, v2_d;
    logic                  own2_q, own2_d;
    logic                  a_rvalid;
    logic                  b_rvalid;

    assign adv = |gnt;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({b_if.valid, a_if.valid}),
        .adv (adv),
        .gnt (gnt)
    );

    assign a_if.ready = gnt[PORT_A];
    assign b_if.ready = gnt[PORT_B];

    // Idle cycles drop the write strobe but keep address/data stable.
    always_comb begin
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        v1_d       = 1'b0;
        own1_d     = own1_q;
        if (gnt[PORT_A]) begin
            ram_we_d   = a_if.we;
            ram_addr_d = a_if.addr;
            ram_din_d  = a_if.wdata;
            v1_d       = 1'b1;
            own1_d     = PORT_A;
        end else if (gnt[PORT_B]) begin
            ram_we_d   = b_if.we;
            ram_addr_d = b_if.addr;
            ram_din_d  = b_if.wdata;
            v1_d       = 1'b1;
            own1_d     = PORT_B;
        end
        v2_d   = v1_q;
        own2_d = own1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            v1_q       <= 1'b0;
            own1_q     <= PORT_A;
            v2_q       <= 1'b0;
            own2_q     <= PORT_A;
        end else begin
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            v1_q       <= v1_d;
            own1_q     <= own1_d;
            v2_q       <= v2_d;
            own2_q     <= own2_d;
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

    assign a_rvalid    = v2_q & (own2_q == PORT_A);
    assign b_rvalid    = v2_q & (own2_q == PORT_B);
    assign a_if.rvalid = a_rvalid;
    assign b_if.rvalid = b_rvalid;
    assign a_if.rdata  = a_rvalid ? ram_dout : '0;
    assign b_if.rdata  = b_rvalid ? ram_dout : '0;

endmodule
